// File: rtl/ntt_stage_ctrl.sv
// rtl/ntt_stage_ctrl.sv - Stage/butterfly sequencer for the 256-point Kyber NTT/INTT datapath.
module ntt_stage_ctrl #(
  parameter int PIPE_DRAIN  = 6,
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_sel,
  input  logic       i_hold,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_e,
  output logic       o_last_e,
  output logic       o_sel,
  output logic [7:0] o_addr_up,
  output logic [7:0] o_addr_dn,
  output logic [6:0] o_zeta_idx,
  output logic [2:0] o_stage
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam bit         NO_DRAIN   = (PIPE_DRAIN == 0);
  localparam logic [4:0] DRAIN_LAST = 5'(NO_DRAIN ? 0 : PIPE_DRAIN - 1);
  // FLUSH holds one cycle beyond F so the done pulse lands in the DONE state itself.
  localparam logic [4:0] FLUSH_NTT  = 5'(PIPE_DRAIN);
  localparam logic [4:0] FLUSH_INTT = 5'(PIPE_DRAIN + MUL_LATENCY);

  state_t     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [6:0] b_q, b_d;
  logic [4:0] cnt_q, cnt_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       e_q, e_d;
  logic       last_e_q, last_e_d;
  logic       sel_q, sel_d;
  logic [7:0] addr_up_q, addr_up_d;
  logic [7:0] addr_dn_q, addr_dn_d;
  logic [6:0] zeta_q, zeta_d;
  logic [2:0] stage_q, stage_d;

  logic       issue;
  logic       iss_sel;
  logic [2:0] iss_s;
  logic [6:0] iss_b;
  logic [2:0] log_len;
  logic [3:0] grp_shift;
  logic [7:0] len;
  logic [7:0] b_ext;
  logic [7:0] grp;
  logic [7:0] up;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    e_d       = 1'b0;
    last_e_d  = 1'b0;
    sel_d     = sel_q;
    addr_up_d = addr_up_q;
    addr_dn_d = addr_dn_q;
    zeta_d    = zeta_q;
    stage_d   = stage_q;
    issue     = 1'b0;
    iss_sel   = sel_q;
    iss_s     = s_q;
    iss_b     = b_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          // Butterfly (0,0) is issued on the accepting edge so o_e rises with o_busy.
          busy_d  = 1'b1;
          sel_d   = i_sel;
          iss_sel = i_sel;
          iss_s   = 3'd0;
          iss_b   = 7'd0;
          issue   = 1'b1;
          s_d     = 3'd0;
          b_d     = 7'd1;
          cnt_d   = 5'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!i_hold) begin
          issue = 1'b1;
          if (b_q == 7'd127) begin
            b_d   = 7'd0;
            cnt_d = 5'd0;
            if (s_q == 3'd6) begin
              state_d = S_FLUSH;
            end else if (NO_DRAIN) begin
              s_d = s_q + 3'd1;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            b_d = b_q + 7'd1;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_RUN;
          s_d     = s_q + 3'd1;
          b_d     = 7'd0;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == (sel_q ? FLUSH_INTT : FLUSH_NTT)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // NTT shrinks len from 128 down to 2; INTT grows it from 2 up to 128.
    log_len   = iss_sel ? (iss_s + 3'd1) : (3'd7 - iss_s);
    grp_shift = {1'b0, log_len} + 4'd1;
    len       = 8'd1 << log_len;
    b_ext     = {1'b0, iss_b};
    grp       = b_ext >> log_len;
    up        = (grp << grp_shift) | (b_ext & (len - 8'd1));

    if (issue) begin
      e_d       = 1'b1;
      last_e_d  = (iss_s == 3'd6);
      stage_d   = iss_s;
      addr_up_d = up;
      addr_dn_d = up + len;
      zeta_d    = iss_sel ? ((7'd127 >> iss_s) - grp[6:0]) : ((7'd1 << iss_s) + grp[6:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      s_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      e_q       <= 1'b0;
      last_e_q  <= 1'b0;
      sel_q     <= 1'b0;
      addr_up_q <= '0;
      addr_dn_q <= '0;
      zeta_q    <= '0;
      stage_q   <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      e_q       <= e_d;
      last_e_q  <= last_e_d;
      sel_q     <= sel_d;
      addr_up_q <= addr_up_d;
      addr_dn_q <= addr_dn_d;
      zeta_q    <= zeta_d;
      stage_q   <= stage_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_e        = e_q;
  assign o_last_e   = last_e_q;
  assign o_sel      = sel_q;
  assign o_addr_up  = addr_up_q;
  assign o_addr_dn  = addr_dn_q;
  assign o_zeta_idx = zeta_q;
  assign o_stage    = stage_q;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb/tb_ntt_stage_ctrl.sv - Scoreboard bench for ntt_stage_ctrl using the reference Kyber loop nest.
module tb_ntt_stage_ctrl;

  localparam int D = 6;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_sel = 1'b0;
  logic       i_hold = 1'b0;
  logic       o_busy, o_done, o_e, o_last_e, o_sel;
  logic [7:0] o_addr_up, o_addr_dn;
  logic [6:0] o_zeta_idx;
  logic [2:0] o_stage;

  ntt_stage_ctrl #(.PIPE_DRAIN(D), .MUL_LATENCY(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_sel     (i_sel),
    .i_hold    (i_hold),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_e       (o_e),
    .o_last_e  (o_last_e),
    .o_sel     (o_sel),
    .o_addr_up (o_addr_up),
    .o_addr_dn (o_addr_dn),
    .o_zeta_idx(o_zeta_idx),
    .o_stage   (o_stage)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int t0 = 0;
  int done_rel = -1;
  int stop_rel = -1;
  int mrel;
  logic mon_on = 1'b0;
  logic exp_sel = 1'b0;
  logic [43:0] exp_q[$];
  logic [43:0] exp_item;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {o_busy, o_done, o_e, o_last_e, o_sel, o_addr_up, o_addr_dn, o_zeta_idx, o_stage};
  endfunction

  task automatic push_exp(input logic sel, input int st, input int b, input int up, input int ln,
                          input int zeta, input int hold_rel, input int hold_n);
    int rel;
    rel = 1 + st * (128 + D) + b;
    if (hold_n > 0 && rel >= hold_rel) rel += hold_n;
    exp_q.push_back({16'(rel), sel, 3'(st), (st == 6), 8'(up), 8'(up + ln), 7'(zeta)});
  endtask

  // Expected issue order straight from the Kyber reference ntt/invntt loops.
  task automatic build_model(input logic sel, input int hold_rel, input int hold_n);
    int k, st, b;
    st = 0;
    if (!sel) begin
      k = 1;
      for (int ln = 128; ln >= 2; ln = ln / 2) begin
        b = 0;
        for (int start = 0; start < 256; start += 2 * ln) begin
          for (int j = start; j < start + ln; j++) begin
            push_exp(sel, st, b, j, ln, k, hold_rel, hold_n);
            b++;
          end
          k++;
        end
        st++;
      end
    end else begin
      k = 127;
      for (int ln = 2; ln <= 128; ln = ln * 2) begin
        b = 0;
        for (int start = 0; start < 256; start += 2 * ln) begin
          for (int j = start; j < start + ln; j++) begin
            push_exp(sel, st, b, j, ln, k, hold_rel, hold_n);
            b++;
          end
          k--;
        end
        st++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mrel = cyc - t0;
      if (o_done) begin
        n_done++;
        check("done_rel", 64'(mrel), 64'(done_rel));
      end
      check("busy", {63'd0, o_busy}, {63'd0, (mrel >= 1 && mrel <= stop_rel)});
      if (o_busy) check("sel", {63'd0, o_sel}, {63'd0, exp_sel});
      if (o_e) begin
        if (exp_q.size() == 0) begin
          check("extra_issue", {63'd0, o_e}, 64'd0);
        end else begin
          exp_item = exp_q.pop_front();
          check("issue", {16'(mrel), o_sel, o_stage, o_last_e, o_addr_up, o_addr_dn, o_zeta_idx},
                exp_item);
        end
      end
    end
  end

  // Called at posedge+2; start is raised in the current cycle.
  task automatic run_op(input logic sel, input int hold_rel, input int hold_n,
                        input int spur_rel, input logic spur_done, input int abort_rel);
    int rel, end_rel, f, n0;
    f  = D + (sel ? M : 0);
    n0 = n_done;
    build_model(sel, hold_rel, hold_n);
    t0       = cyc;
    exp_sel  = sel;
    done_rel = (abort_rel > 0) ? -1 : (896 + 6 * D + f + 1 + hold_n);
    stop_rel = (abort_rel > 0) ? abort_rel : done_rel;
    end_rel  = (abort_rel > 0) ? 1000 : done_rel + 1;
    mon_on   = 1'b1;
    i_start  = 1'b1;
    i_sel    = sel;
    rel      = 0;
    while (rel < end_rel) begin
      @(posedge clk);
      #2;
      rel     = cyc - t0;
      i_sel   = ~sel;
      i_start = (rel == spur_rel) || (spur_done && rel == done_rel);
      i_hold  = (hold_n > 0) && (rel >= hold_rel - 1) && (rel < hold_rel - 1 + hold_n);
      if (abort_rel > 0 && rel == abort_rel) rst = 1'b1;
      if (abort_rel > 0 && rel == abort_rel + 1) begin
        rst = 1'b0;
        check("abort_outputs", all_outputs(), 64'd0);
        exp_q.delete();
      end
    end
    i_start = 1'b0;
    i_hold  = 1'b0;
    check("done_count", 64'(n_done - n0), (abort_rel > 0) ? 64'd0 : 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", all_outputs(), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;
    run_op(1'b0, 0, 0, -1, 1'b0, 0);
    run_op(1'b1, 0, 0, -1, 1'b0, 0);
    run_op(1'b0, 1 + 2 * (128 + D) + 10, 3, -1, 1'b0, 0);
    run_op(1'b0, 0, 0, 300, 1'b1, 0);
    run_op(1'b1, 0, 0, -1, 1'b0, 0);
    run_op(1'b0, 0, 0, -1, 1'b0, 1 + 3 * (128 + D) + 50);
    run_op(1'b0, 0, 0, -1, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
